// File: rtl/mips_pkg.sv
// Shared CPU definitions: MDU operation encodings, default busy-window lengths
// and a small two's-complement helper used by the divider.
package mips_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational MULT/MULTU/DIV/DIVU datapath producing {hi, lo}; a zero
// divisor returns the current HI/LO so the commit leaves them unchanged.
module mdu_calc
  import mips_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] a_mag, b_mag, div_s, div_u;
  logic        [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic               b_zero;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case.
  assign b_zero = (B == 32'd0);
  assign a_mag  = A[31] ? neg32(A) : A;
  assign b_mag  = B[31] ? neg32(B) : B;
  assign div_s  = b_zero ? 32'd1 : b_mag;
  assign div_u  = b_zero ? 32'd1 : B;
  assign q_mag  = a_mag / div_s;
  assign r_mag  = a_mag % div_s;
  assign q_s    = (A[31] ^ B[31]) ? neg32(q_mag) : q_mag;
  assign r_s    = A[31] ? neg32(r_mag) : r_mag;
  assign q_u    = A / div_u;
  assign r_u    = A % div_u;

  always_comb begin
    result = {hi, lo};
    case (MDUOp)
      MDU_MULT:  result = $unsigned(prod_s);
      MDU_MULTU: result = prod_u;
      MDU_DIV:   if (!b_zero) result = {r_s, q_s};
      MDU_DIVU:  if (!b_zero) result = {r_u, q_u};
      default:   result = {hi, lo};
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: fixed-length busy window per operation,
// HI/LO architectural registers and the MFHI/MFLO read port.
module e_mdu
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  input  logic        start,
  output logic        busy,
  output logic [31:0] out
);

  logic [31:0] hi, lo, pend_hi, pend_lo;
  logic [3:0]  cnt;
  logic [63:0] calc;
  logic        is_arith, is_div;

  mdu_calc u_calc (
    .A      (A),
    .B      (B),
    .MDUOp  (MDUOp),
    .hi     (hi),
    .lo     (lo),
    .result (calc)
  );

  assign is_arith = (MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU) ||
                    (MDUOp == MDU_DIV)  || (MDUOp == MDU_DIVU);
  assign is_div   = (MDUOp == MDU_DIV)  || (MDUOp == MDU_DIVU);

  // cnt != 0 is the RUN state; the result is held in pend_* until the last edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        hi   <= pend_hi;
        lo   <= pend_lo;
        busy <= 1'b0;
      end
    end else if (start) begin
      if (is_arith) begin
        {pend_hi, pend_lo} <= calc;
        cnt  <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        busy <= 1'b1;
      end
    end else if (MDUOp == MDU_MTHI) begin
      hi <= A;
    end else if (MDUOp == MDU_MTLO) begin
      lo <= A;
    end
  end

  always_comb begin
    out = 32'd0;
    if (MDUOp == MDU_MFHI)      out = hi;
    else if (MDUOp == MDU_MFLO) out = lo;
  end

endmodule
